pc_predict_reg: RTL and testbench

Parametrised fetch-address generator, successor to the plain PC register. Holds the fetch PC and, on each advance, selects the next PC from a direct-mapped branch target buffer (BTB) with 2-bit saturating counters instead of always taking PC+4. Sits at the front of the fetch stage. Fed by the stall controller and by branch/jump resolution in execute; drives the instruction-fetch address and a per-PC prediction bit that travels down the pipe.

---
 rtl/pc_predict_reg.sv | 100 ++++++++++
 tb/tb_pc_predict_reg.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/pc_predict_reg.sv
// Fetch PC register with a direct-mapped BTB and 2-bit saturating counters.
// Optional predictor: define BTB_PREDICT_EN to build it; otherwise PC+4 only.
module pc_predict_reg #(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    BTB_ENTRIES = 64,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy,
  input  logic                  stall_i,
  input  logic                  redirect_en_i,
  input  logic [ADDR_WIDTH-1:0] redirect_pc_i,
  input  logic                  update_en_i,
  input  logic [ADDR_WIDTH-1:0] update_pc_i,
  input  logic                  update_taken_i,
  input  logic [ADDR_WIDTH-1:0] update_target_i,
  output logic [ADDR_WIDTH-1:0] pc_o,
  output logic                  pred_taken_o,
  output logic [ADDR_WIDTH-1:0] pred_target_o
);

  localparam int IDX   = $clog2(BTB_ENTRIES);
  localparam int TAG_W = ADDR_WIDTH - IDX - 2;

  logic [ADDR_WIDTH-1:0] pc_q;
  logic [ADDR_WIDTH-1:0] pc_plus4;

  assign pc_o     = pc_q;
  assign pc_plus4 = pc_q + ADDR_WIDTH'(4);

`ifdef BTB_PREDICT_EN
  logic [BTB_ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]       tag_q    [BTB_ENTRIES];
  logic [ADDR_WIDTH-1:0]  target_q [BTB_ENTRIES];
  logic [1:0]             cnt_q    [BTB_ENTRIES];

  logic [IDX-1:0]   rd_idx, wr_idx;
  logic [TAG_W-1:0] rd_tag, wr_tag;
  logic             rd_hit, wr_hit, wr_en;
  logic             unused_update_bits;

  assign rd_idx = pc_q[IDX+1:2];
  assign rd_tag = pc_q[ADDR_WIDTH-1:IDX+2];
  assign wr_idx = update_pc_i[IDX+1:2];
  assign wr_tag = update_pc_i[ADDR_WIDTH-1:IDX+2];
  assign unused_update_bits = ^update_pc_i[1:0];

  assign rd_hit        = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
  assign wr_hit        = valid_q[wr_idx] && (tag_q[wr_idx] == wr_tag);
  assign wr_en         = update_en_i && rdy && !rst;
  assign pred_taken_o  = rd_hit && cnt_q[rd_idx][1];
  assign pred_target_o = pred_taken_o ? target_q[rd_idx] : pc_plus4;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else if (wr_en && !wr_hit && update_taken_i) begin
      valid_q[wr_idx] <= 1'b1;
    end
  end

  // NOTE: tag/target/counter arrays are deliberately not reset; valid_q alone
  // gates every hit, so this storage can map onto plain RAM without reset logic.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      if (wr_hit) begin
        if (update_taken_i) begin
          target_q[wr_idx] <= update_target_i;
          if (cnt_q[wr_idx] != 2'b11) cnt_q[wr_idx] <= cnt_q[wr_idx] + 2'd1;
        end else if (cnt_q[wr_idx] != 2'b00) begin
          cnt_q[wr_idx] <= cnt_q[wr_idx] - 2'd1;
        end
      end else if (update_taken_i) begin
        tag_q[wr_idx]    <= wr_tag;
        target_q[wr_idx] <= update_target_i;
        cnt_q[wr_idx]    <= 2'b10;
      end
    end
  end
`else
  logic unused_update;

  assign unused_update = ^{update_en_i, update_pc_i, update_taken_i, update_target_i};
  assign pred_taken_o  = 1'b0;
  assign pred_target_o = pc_plus4;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, matching the lookup-before-update behaviour.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else if (rdy) begin
      if (redirect_en_i) pc_q <= redirect_pc_i;
      else if (!stall_i) pc_q <= pred_target_o;
    end
  end

endmodule

// File: tb/tb_pc_predict_reg.sv
// Directed self-checking bench for pc_predict_reg; expectations follow
// whether BTB_PREDICT_EN is defined for this build.
module tb_pc_predict_reg;

`ifdef BTB_PREDICT_EN
  localparam bit BTB = 1'b1;
`else
  localparam bit BTB = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, rdy, stall_i, redirect_en_i, update_en_i, update_taken_i;
  logic [31:0] redirect_pc_i, update_pc_i, update_target_i;
  logic [31:0] pc_o, pred_target_o;
  logic        pred_taken_o;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pc_predict_reg #(.ADDR_WIDTH(32), .BTB_ENTRIES(64), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .stall_i(stall_i),
    .redirect_en_i(redirect_en_i), .redirect_pc_i(redirect_pc_i),
    .update_en_i(update_en_i), .update_pc_i(update_pc_i),
    .update_taken_i(update_taken_i), .update_target_i(update_target_i),
    .pc_o(pc_o), .pred_taken_o(pred_taken_o), .pred_target_o(pred_target_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic rs, input logic rd, input logic st,
                       input logic re, input logic [31:0] rpc,
                       input logic ue, input logic [31:0] upc,
                       input logic ut, input logic [31:0] utg);
    rst = rs; rdy = rd; stall_i = st;
    redirect_en_i = re; redirect_pc_i = rpc;
    update_en_i = ue; update_pc_i = upc; update_taken_i = ut; update_target_i = utg;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Common cycle shapes: idle advance, redirect, update, redirect+update.
  task automatic idle();
    drive(0, 1, 0, 0, 0, 0, 0, 0, 0); tick();
  endtask

  task automatic redir(input logic [31:0] rpc);
    drive(0, 1, 0, 1, rpc, 0, 0, 0, 0); tick();
  endtask

  task automatic upd(input logic [31:0] upc, input logic ut, input logic [31:0] utg);
    drive(0, 1, 0, 0, 0, 1, upc, ut, utg); tick();
  endtask

  task automatic expect_pc(input string tag, input logic [31:0] pc,
                           input logic pt, input logic [31:0] tgt);
    check({tag, ".pc"}, pc_o, pc);
    check({tag, ".taken"}, {31'b0, pred_taken_o}, {31'b0, pt});
    check({tag, ".target"}, pred_target_o, tgt);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    drive(1, 1, 0, 0, 0, 0, 0, 0, 0);
    tick(); tick();
    expect_pc("reset", 32'h0, 0, 32'h4);

    idle(); expect_pc("free1", 32'h4, 0, 32'h8);
    idle(); expect_pc("free2", 32'h8, 0, 32'hC);
    idle(); expect_pc("free3", 32'hC, 0, 32'h10);

    // Allocate 0x10 -> 0x100 while fetch moves onto 0x10.
    upd(32'h10, 1, 32'h100);
    expect_pc("alloc", 32'h10, BTB, BTB ? 32'h100 : 32'h14);
    idle();
    check("taken_next", pc_o, BTB ? 32'h100 : 32'h14);

    // Two not-taken reports drive the counter 10 -> 01 -> 00.
    upd(32'h10, 0, 32'h0);
    check("nt1_pc", pc_o, BTB ? 32'h104 : 32'h18);
    upd(32'h10, 0, 32'h0);
    check("nt2_pc", pc_o, BTB ? 32'h108 : 32'h1C);
    redir(32'h10);
    expect_pc("revisit", 32'h10, 0, 32'h14);
    idle();
    check("revisit_next", pc_o, 32'h14);

    // 0x110 aliases index 4 with a different tag and replaces the entry.
    drive(0, 1, 0, 1, 32'h10, 1, 32'h110, 1, 32'h300); tick();
    expect_pc("alias_old", 32'h10, 0, 32'h14);
    redir(32'h110);
    expect_pc("alias_new", 32'h110, BTB, BTB ? 32'h300 : 32'h114);

    // Redirect beats stall and a predicted hit; stall alone holds.
    drive(0, 1, 1, 1, 32'h200, 0, 0, 0, 0); tick();
    check("redir_stall", pc_o, 32'h200);
    drive(0, 1, 1, 0, 0, 0, 0, 0, 0); tick();
    check("stall_hold", pc_o, 32'h200);
    redir(32'h110);

    // Update during a stalled lookup of the same entry: old contents until the edge.
    drive(0, 1, 1, 0, 0, 1, 32'h110, 0, 32'h0);
    check("pre_update", {31'b0, pred_taken_o}, {31'b0, BTB});
    tick();
    expect_pc("post_update", 32'h110, 0, 32'h114);

    // rdy low freezes PC and table despite update and redirect pulses.
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, i[0], 32'h500, 1, 32'h110, 1, 32'h400); tick();
      expect_pc($sformatf("frozen%0d", i), 32'h110, 0, 32'h114);
    end
    idle();
    check("thaw", pc_o, 32'h114);

    // Entry survived the freeze: one taken report makes it weak-taken again.
    drive(0, 1, 0, 1, 32'h110, 1, 32'h110, 1, 32'h400); tick();
    expect_pc("retrain", 32'h110, BTB, BTB ? 32'h400 : 32'h114);

    // Reset overrides redirect and update, and clears all valid bits.
    drive(1, 1, 0, 1, 32'h700, 1, 32'h0, 1, 32'h800); tick();
    expect_pc("rst_mid", 32'h0, 0, 32'h4);
    redir(32'h110);
    expect_pc("rst_cleared", 32'h110, 0, 32'h114);

    // Wrap-around of PC+4 at the top of the address space.
    redir(32'hFFFF_FFFC);
    expect_pc("wrap_pre", 32'hFFFF_FFFC, 0, 32'h0);
    idle();
    check("wrap", pc_o, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
